systolic_input_sequencer: RTL and testbench
===========================================

SYSTOLIC_INPUT_SEQUENCER -- requirements
Module: systolic_input_sequencer

Interface
REQ-001 Parameter SIZE, default 4: array dimension (lanes per operand).
REQ-002 Parameter I_BITS, default 8: operand element width.
REQ-003 i_clock  input  1  single clock; all logic SHALL be rising-edge on it.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_load_valid  input  1  load beat valid.
REQ-006 o_load_ready  output  1  sequencer accepts a load beat.
REQ-007 i_load_row  input  SIZE*I_BITS  one matrix row; element c in bits [c*I_BITS +: I_BITS].
REQ-008 i_start  input  1  request to stream loaded matrices.
REQ-009 i_matrix_size  input  3  matrix-size code, captured on accepted start.
REQ-010 o_matrix_size  output  3  captured size code, held until next accepted start.
REQ-011 o_array_reset  output  1  reset pulse for the systolic array.
REQ-012 o_a_full  output  SIZE*I_BITS  skewed A lanes; lane k in bits [k*I_BITS +: I_BITS].
REQ-013 o_b_full  output  SIZE*I_BITS  skewed B lanes, same packing.
REQ-014 o_busy  output  1  high from accepted start until done.
REQ-015 o_done  output  1  one-cycle completion pulse.

Function
REQ-016 States SHALL be LOAD, FULL, CLR, STREAM, DONE.
REQ-017 LOAD: o_load_ready=1; each beat with i_load_valid&o_load_ready SHALL store i_load_row; rows 0..SIZE-1 go to A row 0..SIZE-1, rows SIZE..2*SIZE-1 go to B row 0..SIZE-1.
REQ-018 After the 2*SIZE-th accepted beat the state SHALL become FULL on the next edge.
REQ-019 o_load_ready SHALL be 0 in every state other than LOAD; i_load_valid outside LOAD SHALL be ignored.
REQ-020 i_start SHALL be accepted only in FULL; i_start in any other state SHALL be ignored with no side effect.
REQ-021 Accepted start SHALL capture i_matrix_size and move to CLR; CLR lasts exactly one cycle with o_array_reset=1, o_busy=1.
REQ-022 STREAM SHALL last exactly 2*SIZE-1 cycles, beat index s=0..2*SIZE-2, with o_busy=1.
REQ-023 In beat s, lane k of o_a_full SHALL equal A[k][s-k] and lane k of o_b_full SHALL equal B[s-k][k] when 0<=s-k<SIZE, else zero.
REQ-024 o_a_full/o_b_full SHALL be registered and zero in every state except STREAM.
REQ-025 After the last beat, DONE SHALL last one cycle with o_done=1, o_busy=0, then return to LOAD with row count cleared.
REQ-026 Stored matrices are not cleared on DONE; a new load overwrites them row by row.
REQ-027 Beat counter width SHALL be $clog2(2*SIZE); load counter width $clog2(2*SIZE+1); no wrap in either.

Reset
REQ-028 i_reset SHALL, on the next edge, force state LOAD, load count 0, beat count 0, o_array_reset=0, o_busy=0, o_done=0, o_a_full=0, o_b_full=0, o_matrix_size=0, regardless of current state (including mid-STREAM).
REQ-029 Matrix storage contents need not be reset.

Structure
REQ-030 SIZE/I_BITS defaults and state encoding SHALL live in shared package systolic_pkg.
REQ-031 Operand storage SHALL be one sub-module, systolic_matrix_buffer (SIZE x SIZE x I_BITS, row write port, per-lane diagonal read), instantiated twice (A, B).

Verification (SIZE=4, I_BITS=8)
REQ-032 Load A=identity, B[r][c]=4r+c+1, start -> one-cycle o_array_reset; beat 0 lane0 a=1, b=1, others 0; beat 6 lane3 a=1, b=16; 7 beats; o_done one cycle after beat 6.
REQ-033 Load 5 rows then pulse i_start -> ignored: o_busy=0, o_array_reset=0, o_load_ready stays 1.
REQ-034 Hold i_load_valid for 10 cycles -> exactly 8 beats accepted, o_load_ready=0 from cycle 9.
REQ-035 Assert i_reset at beat 3 -> next cycle all lanes 0, o_busy=0, o_load_ready=1, load count 0.
REQ-036 i_matrix_size=3'd5 at start, then 3'd2 during STREAM -> o_matrix_size=5 throughout.
REQ-037 Two back-to-back runs with different B -> second run's lanes reflect new B exactly per REQ-023.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared defaults and the sequencer state encoding for the systolic input path.
package systolic_pkg;

  localparam int SIZE_DEF   = 4;
  localparam int I_BITS_DEF = 8;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_FULL   = 3'd1,
    ST_CLR    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/systolic_matrix_buffer.sv
// SIZE x SIZE operand store with a whole-row write port and a skewed
// (anti-diagonal) read: lane k returns the element sitting on diagonal beat s.
// TRANSPOSE=0 reads lane k from row k (A operand, A[k][s-k]);
// TRANSPOSE=1 reads lane k from column k (B operand, B[s-k][k]).
module systolic_matrix_buffer
  import systolic_pkg::*;
#(
  parameter int SIZE      = SIZE_DEF,
  parameter int I_BITS    = I_BITS_DEF,
  parameter int ROW_W     = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter int BEAT_W    = $clog2(2 * SIZE),
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [ROW_W-1:0]         wr_row,
  input  logic [SIZE*I_BITS-1:0]   wr_data,
  input  logic [BEAT_W-1:0]        rd_beat,
  output logic [SIZE*I_BITS-1:0]   rd_lanes
);

  logic [I_BITS-1:0] mem [SIZE][SIZE];

  // Row write: contents are not reset, a new load simply overwrites them.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int c = 0; c < SIZE; c++) begin
        mem[wr_row][c] <= wr_data[c*I_BITS +: I_BITS];
      end
    end
  end

  // Diagonal read: lane k picks offset j where k + j equals the beat index,
  // which avoids any signed s-k arithmetic; lanes off the diagonal read zero.
  always_comb begin
    rd_lanes = '0;
    for (int k = 0; k < SIZE; k++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (rd_beat == BEAT_W'(k + j)) begin
          rd_lanes[k*I_BITS +: I_BITS] = TRANSPOSE ? mem[j][k] : mem[k][j];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_input_sequencer.sv
// Loads an A and a B matrix row by row, then on start pulses the array reset
// and streams both operands skewed across 2*SIZE-1 beats into a systolic array.
module systolic_input_sequencer
  import systolic_pkg::*;
#(
  parameter int SIZE   = SIZE_DEF,
  parameter int I_BITS = I_BITS_DEF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [SIZE*I_BITS-1:0]  i_load_row,
  input  logic                    i_start,
  input  logic [2:0]              i_matrix_size,
  output logic [2:0]              o_matrix_size,
  output logic                    o_array_reset,
  output logic [SIZE*I_BITS-1:0]  o_a_full,
  output logic [SIZE*I_BITS-1:0]  o_b_full,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int LOAD_W = $clog2(2 * SIZE + 1);
  localparam int BEAT_W = $clog2(2 * SIZE);
  localparam int ROW_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int VEC_W  = SIZE * I_BITS;

  state_t              state;
  state_t              next_state;
  logic [LOAD_W-1:0]   load_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   beat_next;
  logic                load_fire;
  logic                start_fire;
  logic                a_wr;
  logic                b_wr;
  logic [ROW_W-1:0]    a_row;
  logic [ROW_W-1:0]    b_row;
  logic [VEC_W-1:0]    a_lanes;
  logic [VEC_W-1:0]    b_lanes;

  // Beats are only taken in LOAD; the first SIZE go to A, the next SIZE to B.
  assign load_fire  = (state == ST_LOAD) && i_load_valid;
  assign start_fire = (state == ST_FULL) && i_start;
  assign a_wr       = load_fire && (load_cnt <  LOAD_W'(SIZE));
  assign b_wr       = load_fire && (load_cnt >= LOAD_W'(SIZE));
  assign a_row      = ROW_W'(load_cnt);
  assign b_row      = ROW_W'(load_cnt - LOAD_W'(SIZE));

  systolic_matrix_buffer #(
    .SIZE(SIZE), .I_BITS(I_BITS), .ROW_W(ROW_W), .BEAT_W(BEAT_W), .TRANSPOSE(1'b0)
  ) u_buf_a (
    .clock(i_clock), .wr_en(a_wr), .wr_row(a_row), .wr_data(i_load_row),
    .rd_beat(beat_next), .rd_lanes(a_lanes)
  );

  systolic_matrix_buffer #(
    .SIZE(SIZE), .I_BITS(I_BITS), .ROW_W(ROW_W), .BEAT_W(BEAT_W), .TRANSPOSE(1'b1)
  ) u_buf_b (
    .clock(i_clock), .wr_en(b_wr), .wr_row(b_row), .wr_data(i_load_row),
    .rd_beat(beat_next), .rd_lanes(b_lanes)
  );

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_LOAD;
    else         state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD:   if (load_fire && (load_cnt == LOAD_W'(2 * SIZE - 1))) next_state = ST_FULL;
      ST_FULL:   if (i_start) next_state = ST_CLR;
      ST_CLR:    next_state = ST_STREAM;
      ST_STREAM: if (beat_cnt == BEAT_W'(2 * SIZE - 2)) next_state = ST_DONE;
      ST_DONE:   next_state = ST_LOAD;
      default:   next_state = ST_LOAD;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    o_load_ready  = (state == ST_LOAD);
    o_array_reset = (state == ST_CLR);
    o_busy        = (state == ST_CLR) || (state == ST_STREAM);
    o_done        = (state == ST_DONE);
  end

  // Beat about to be presented: 0 when leaving CLR, s+1 while streaming.
  always_comb begin
    beat_next = '0;
    if (state == ST_STREAM) beat_next = beat_cnt + 1'b1;
  end

  // Load/beat counters and the captured matrix-size code.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      load_cnt      <= '0;
      beat_cnt      <= '0;
      o_matrix_size <= '0;
    end else begin
      if (state == ST_DONE) load_cnt <= '0;
      else if (load_fire)   load_cnt <= load_cnt + 1'b1;
      beat_cnt <= (next_state == ST_STREAM) ? beat_next : '0;
      if (start_fire) o_matrix_size <= i_matrix_size;
    end
  end

  // Lane registers load the diagonal for the beat being entered, so the
  // registered value lines up with beat_cnt and is zero outside STREAM.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_a_full <= '0;
      o_b_full <= '0;
    end else if (next_state == ST_STREAM) begin
      o_a_full <= a_lanes;
      o_b_full <= b_lanes;
    end else begin
      o_a_full <= '0;
      o_b_full <= '0;
    end
  end

endmodule

// File: tb/tb_systolic_input_sequencer.sv
// Bench for systolic_input_sequencer at SIZE=4, I_BITS=8: directed load/stream
// sequences, a table of diagonal spot values, and random back-to-back runs
// compared against a matrix-level reference model.
module tb_systolic_input_sequencer;

  localparam int SIZE   = 4;
  localparam int I_BITS = 8;
  localparam int VEC_W  = SIZE * I_BITS;
  localparam int BEATS  = 2 * SIZE - 1;

  logic              clk;
  logic              i_reset;
  logic              i_load_valid;
  logic              o_load_ready;
  logic [VEC_W-1:0]  i_load_row;
  logic              i_start;
  logic [2:0]        i_matrix_size;
  logic [2:0]        o_matrix_size;
  logic              o_array_reset;
  logic [VEC_W-1:0]  o_a_full;
  logic [VEC_W-1:0]  o_b_full;
  logic              o_busy;
  logic              o_done;

  systolic_input_sequencer #(.SIZE(SIZE), .I_BITS(I_BITS)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_load_valid(i_load_valid),
    .o_load_ready(o_load_ready), .i_load_row(i_load_row), .i_start(i_start),
    .i_matrix_size(i_matrix_size), .o_matrix_size(o_matrix_size),
    .o_array_reset(o_array_reset), .o_a_full(o_a_full), .o_b_full(o_b_full),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference matrices as the bench believes they were loaded.
  logic [I_BITS-1:0] ma [SIZE][SIZE];
  logic [I_BITS-1:0] mb [SIZE][SIZE];
  logic [VEC_W-1:0]  rows_q [2*SIZE];
  logic [VEC_W-1:0]  cap_a [BEATS];
  logic [VEC_W-1:0]  cap_b [BEATS];

  typedef struct {
    int                s;
    int                k;
    logic [I_BITS-1:0] a;
    logic [I_BITS-1:0] b;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected skewed vector for beat s, from the matrix definition directly.
  function automatic logic [VEC_W-1:0] exp_lanes(input int s, input bit is_b);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int k = 0; k < SIZE; k++) begin
      int d;
      d = s - k;
      if (d >= 0 && d < SIZE)
        v[k*I_BITS +: I_BITS] = is_b ? mb[d][k] : ma[k][d];
    end
    return v;
  endfunction

  function automatic void model_store(input int idx, input logic [VEC_W-1:0] row);
    for (int c = 0; c < SIZE; c++) begin
      if (idx < SIZE) ma[idx][c] = row[c*I_BITS +: I_BITS];
      else            mb[idx-SIZE][c] = row[c*I_BITS +: I_BITS];
    end
  endfunction

  // Push rows_q[lo..hi] with valid held; ready must be high for each beat.
  task automatic load_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      check("ready_before_beat", o_load_ready, 1);
      i_load_row   = rows_q[i];
      i_load_valid = 1'b1;
      model_store(i, rows_q[i]);
      tick();
    end
    i_load_valid = 1'b0;
    i_load_row   = '0;
  endtask

  task automatic check_idle_reset();
    check("rst_ready", o_load_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_arr_reset", o_array_reset, 0);
    check("rst_a", o_a_full, 0);
    check("rst_b", o_b_full, 0);
    check("rst_msize", o_matrix_size, 0);
  endtask

  // Start from FULL and check CLR, every stream beat, DONE and return to LOAD.
  task automatic run_stream(input logic [2:0] msz, input bit hold_start);
    check("full_ready_low", o_load_ready, 0);
    i_start       = 1'b1;
    i_matrix_size = msz;
    tick();
    i_start       = hold_start;
    i_matrix_size = ~msz;
    check("clr_arr_reset", o_array_reset, 1);
    check("clr_busy", o_busy, 1);
    check("clr_a_zero", o_a_full, 0);
    check("clr_b_zero", o_b_full, 0);
    check("clr_msize", o_matrix_size, msz);
    for (int s = 0; s < BEATS; s++) begin
      tick();
      if (s == 2) i_matrix_size = 3'd2;
      cap_a[s] = o_a_full;
      cap_b[s] = o_b_full;
      check("beat_a", o_a_full, exp_lanes(s, 1'b0));
      check("beat_b", o_b_full, exp_lanes(s, 1'b1));
      check("beat_busy", {o_busy, o_array_reset, o_done, o_load_ready}, 4'b1000);
      check("beat_msize", o_matrix_size, msz);
    end
    tick();
    check("done_pulse", {o_done, o_busy}, 2'b10);
    check("done_lanes", {o_a_full, o_b_full}, 0);
    tick();
    i_start = 1'b0;
    check("after_done", {o_done, o_busy, o_load_ready}, 3'b001);
    check("after_done_msize", o_matrix_size, msz);
  endtask

  initial begin
    i_reset       = 1'b1;
    i_load_valid  = 1'b0;
    i_load_row    = '0;
    i_start       = 1'b0;
    i_matrix_size = '0;
    tick();
    tick();
    i_reset = 1'b0;
    check_idle_reset();

    // Identity A, B[r][c] = 4r+c+1, with a size-code change during STREAM.
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        rows_q[r][c*I_BITS +: I_BITS]      = (r == c) ? 8'd1 : 8'd0;
        rows_q[SIZE+r][c*I_BITS +: I_BITS] = 8'(4 * r + c + 1);
      end
    end
    load_range(0, 2*SIZE-1);
    check("loaded_ready_low", o_load_ready, 0);
    run_stream(3'd5, 1'b0);

    tbl[0] = '{s: 0, k: 0, a: 8'd1, b: 8'd1};
    tbl[1] = '{s: 0, k: 1, a: 8'd0, b: 8'd0};
    tbl[2] = '{s: 6, k: 3, a: 8'd1, b: 8'd16};
    tbl[3] = '{s: 3, k: 0, a: 8'd0, b: 8'd13};
    tbl[4] = '{s: 3, k: 3, a: 8'd0, b: 8'd4};
    tbl[5] = '{s: 3, k: 1, a: 8'd0, b: 8'd10};
    tbl[6] = '{s: 2, k: 1, a: 8'd1, b: 8'd6};
    tbl[7] = '{s: 4, k: 2, a: 8'd1, b: 8'd11};
    for (int i = 0; i < 8; i++) begin
      logic [VEC_W-1:0] va, vb;
      va = cap_a[tbl[i].s];
      vb = cap_b[tbl[i].s];
      check("tbl_a", va[tbl[i].k*I_BITS +: I_BITS], tbl[i].a);
      check("tbl_b", vb[tbl[i].k*I_BITS +: I_BITS], tbl[i].b);
    end

    // Start during a partial load is ignored and the load continues.
    for (int i = 0; i < 2*SIZE; i++) rows_q[i] = $urandom;
    load_range(0, 4);
    i_start       = 1'b1;
    i_matrix_size = 3'd3;
    tick();
    i_start = 1'b0;
    check("early_start_busy", o_busy, 0);
    check("early_start_arr", o_array_reset, 0);
    check("early_start_ready", o_load_ready, 1);
    check("early_start_msize", o_matrix_size, 3'd5);
    load_range(5, 2*SIZE-1);
    check("partial_full", o_load_ready, 0);
    run_stream(3'd1, 1'b1);

    // Valid held for 10 cycles: only the first 8 beats are stored.
    for (int i = 0; i < 10; i++) begin
      logic [VEC_W-1:0] row;
      row = $urandom;
      check("hold_ready", o_load_ready, (i < 2*SIZE) ? 1'b1 : 1'b0);
      if (i < 2*SIZE) model_store(i, row);
      i_load_row   = row;
      i_load_valid = 1'b1;
      tick();
    end
    i_load_valid = 1'b0;
    run_stream(3'd6, 1'b0);

    // Reset in the middle of STREAM (beat 3).
    for (int i = 0; i < 2*SIZE; i++) rows_q[i] = $urandom;
    load_range(0, 2*SIZE-1);
    i_start       = 1'b1;
    i_matrix_size = 3'd7;
    tick();
    i_start = 1'b0;
    for (int s = 0; s <= 3; s++) tick();
    check("pre_reset_busy", o_busy, 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_idle_reset();
    load_range(0, 2*SIZE-1);
    check("reload_full", o_load_ready, 0);
    run_stream(3'd4, 1'b0);

    // Back-to-back random runs; after the first only B changes.
    for (int i = 0; i < 2*SIZE; i++) rows_q[i] = $urandom;
    for (int it = 0; it < 4; it++) begin
      if (it > 0) for (int i = SIZE; i < 2*SIZE; i++) rows_q[i] = $urandom;
      load_range(0, 2*SIZE-1);
      run_stream(3'($urandom_range(0, 7)), it[0]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
